// File: rtl/gap_state_detector.sv
// EDM gap classifier: 8-sample moving average on current/voltage, debounced
// threshold conditions and a pulse-synchronous IDLE/OPEN/DISCHARGE/SHORT FSM.
module gap_state_detector #(
  parameter int                 AVG_LOG2   = 3,
  parameter logic signed [15:0] V_OPEN_TH  = 16'sd2000,
  parameter logic signed [15:0] V_SHORT_TH = 16'sd300,
  parameter logic signed [15:0] I_DISCH_TH = 16'sd500,
  parameter int                 DEBOUNCE   = 4
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               pulse_on,
  input  logic signed [15:0] sample_current,
  input  logic signed [15:0] sample_voltage,
  output logic signed [15:0] avg_current,
  output logic signed [15:0] avg_voltage,
  output logic [1:0]         gap_state,
  output logic               discharge_start,
  output logic               discharge_end,
  output logic [15:0]        delay_cycles,
  output logic [15:0]        discharge_cycles
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_DISCH = 2'd2,
    S_SHORT = 2'd3
  } state_t;

  logic signed [15:0] i_win_q [N];
  logic signed [15:0] i_win_d [N];
  logic signed [15:0] v_win_q [N];
  logic signed [15:0] v_win_d [N];
  logic signed [SW-1:0] i_sum_q, i_sum_d;
  logic signed [SW-1:0] v_sum_q, v_sum_d;

  state_t      state_q, state_d;
  logic [15:0] delay_cnt_q, delay_cnt_d;
  logic [15:0] len_cnt_q, len_cnt_d;
  logic [15:0] delay_cycles_q, delay_cycles_d;
  logic [15:0] discharge_cycles_q, discharge_cycles_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic [DW-1:0] disch_cnt_q, disch_cnt_d;
  logic [DW-1:0] short_cnt_q, short_cnt_d;

  logic        disch_cond, short_cond;
  logic        disch_met, short_met;
  logic        state_change;
  logic [15:0] delay_inc, len_inc;

  // Running sum: add the incoming sample, drop the one falling out of the window.
  always_comb begin
    i_win_d[0] = sample_current;
    v_win_d[0] = sample_voltage;
    for (int k = 1; k < N; k++) begin
      i_win_d[k] = i_win_q[k-1];
      v_win_d[k] = v_win_q[k-1];
    end
    i_sum_d = i_sum_q + SW'(sample_current) - SW'(i_win_q[N-1]);
    v_sum_d = v_sum_q + SW'(sample_voltage) - SW'(v_win_q[N-1]);
  end

  // Dropping the low bits is an arithmetic shift that rounds toward -inf.
  assign avg_current = i_sum_q[SW-1:AVG_LOG2];
  assign avg_voltage = v_sum_q[SW-1:AVG_LOG2];

  assign disch_cond = (avg_current >= I_DISCH_TH) && (avg_voltage >= V_SHORT_TH) &&
                      (avg_voltage < V_OPEN_TH);
  assign short_cond = (avg_current >= I_DISCH_TH) && (avg_voltage < V_SHORT_TH);

  // A condition fires on the edge where its counter would reach DEBOUNCE.
  assign disch_met = disch_cond && (disch_cnt_q == DW'(DEBOUNCE - 1));
  assign short_met = short_cond && (short_cnt_q == DW'(DEBOUNCE - 1));

  assign delay_inc = (delay_cnt_q == 16'hFFFF) ? 16'hFFFF : delay_cnt_q + 16'd1;
  assign len_inc   = (len_cnt_q == 16'hFFFF) ? 16'hFFFF : len_cnt_q + 16'd1;

  always_comb begin
    state_d            = state_q;
    delay_cnt_d        = delay_cnt_q;
    len_cnt_d          = len_cnt_q;
    delay_cycles_d     = delay_cycles_q;
    discharge_cycles_d = discharge_cycles_q;
    start_d            = 1'b0;
    end_d              = 1'b0;
    case (state_q)
      S_IDLE: begin
        delay_cnt_d = 16'd0;
        if (pulse_on) state_d = S_OPEN;
      end
      S_OPEN: begin
        delay_cnt_d = delay_inc;
        if (!pulse_on) begin
          state_d = S_IDLE;
        end else if (disch_met) begin
          state_d        = S_DISCH;
          delay_cycles_d = delay_inc;
          start_d        = 1'b1;
          len_cnt_d      = 16'd1;
        end else if (short_met) begin
          state_d = S_SHORT;
        end
      end
      S_DISCH: begin
        len_cnt_d = len_inc;
        if (!pulse_on || short_met) begin
          state_d            = pulse_on ? S_SHORT : S_IDLE;
          discharge_cycles_d = len_cnt_q;
          end_d              = 1'b1;
        end
      end
      S_SHORT: begin
        if (!pulse_on) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_change = (state_d != state_q);

  always_comb begin
    disch_cnt_d = '0;
    short_cnt_d = '0;
    if (state_q != S_IDLE && !state_change) begin
      if (disch_cond)
        disch_cnt_d = (disch_cnt_q == DW'(DEBOUNCE)) ? disch_cnt_q : disch_cnt_q + 1'b1;
      if (short_cond)
        short_cnt_d = (short_cnt_q == DW'(DEBOUNCE)) ? short_cnt_q : short_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        i_win_q[k] <= '0;
        v_win_q[k] <= '0;
      end
      i_sum_q            <= '0;
      v_sum_q            <= '0;
      state_q            <= S_IDLE;
      delay_cnt_q        <= '0;
      len_cnt_q          <= '0;
      delay_cycles_q     <= '0;
      discharge_cycles_q <= '0;
      start_q            <= 1'b0;
      end_q              <= 1'b0;
      disch_cnt_q        <= '0;
      short_cnt_q        <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        i_win_q[k] <= i_win_d[k];
        v_win_q[k] <= v_win_d[k];
      end
      i_sum_q            <= i_sum_d;
      v_sum_q            <= v_sum_d;
      state_q            <= state_d;
      delay_cnt_q        <= delay_cnt_d;
      len_cnt_q          <= len_cnt_d;
      delay_cycles_q     <= delay_cycles_d;
      discharge_cycles_q <= discharge_cycles_d;
      start_q            <= start_d;
      end_q              <= end_d;
      disch_cnt_q        <= disch_cnt_d;
      short_cnt_q        <= short_cnt_d;
    end
  end

  assign gap_state        = state_q;
  assign discharge_start  = start_q;
  assign discharge_end    = end_q;
  assign delay_cycles     = delay_cycles_q;
  assign discharge_cycles = discharge_cycles_q;

endmodule

// File: tb/tb_gap_state_detector.sv
// Directed bench for gap_state_detector: a vector table for the main
// open/discharge/short flow plus hand-written multi-cycle corner sequences.
module tb_gap_state_detector;

  logic               sys_clk = 1'b0;
  logic               rst_n;
  logic               pulse_on;
  logic signed [15:0] sample_current;
  logic signed [15:0] sample_voltage;
  logic signed [15:0] avg_current;
  logic signed [15:0] avg_voltage;
  logic [1:0]         gap_state;
  logic               discharge_start;
  logic               discharge_end;
  logic [15:0]        delay_cycles;
  logic [15:0]        discharge_cycles;

  always #5 sys_clk = ~sys_clk;

  gap_state_detector dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .pulse_on         (pulse_on),
    .sample_current   (sample_current),
    .sample_voltage   (sample_voltage),
    .avg_current      (avg_current),
    .avg_voltage      (avg_voltage),
    .gap_state        (gap_state),
    .discharge_start  (discharge_start),
    .discharge_end    (discharge_end),
    .delay_cycles     (delay_cycles),
    .discharge_cycles (discharge_cycles)
  );

  typedef struct {
    logic               pulse;
    logic signed [15:0] cur;
    logic signed [15:0] volt;
    int                 e_ai;
    int                 e_av;
    int                 e_state;
    int                 e_start;
    int                 e_end;
    int                 e_delay;
    int                 e_dcyc;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic p, input int cur, input int volt);
    pulse_on       = p;
    sample_current = 16'(cur);
    sample_voltage = 16'(volt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  function automatic void add_vec(input logic p, input int cur, input int volt,
                                  input int ai, input int av, input int st,
                                  input int stt, input int en, input int dly,
                                  input int dc);
    vec_t v;
    v.pulse = p; v.cur = 16'(cur); v.volt = 16'(volt);
    v.e_ai = ai; v.e_av = av; v.e_state = st; v.e_start = stt; v.e_end = en;
    v.e_delay = dly; v.e_dcyc = dc;
    vecs.push_back(v);
  endfunction

  initial begin
    int starts;

    // Open ramp, settle, step into discharge, step into short, drop pulse.
    for (int k = 1; k <= 8; k++) add_vec(1, 0, 3000, 0, 375 * k, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add_vec(1, 0, 3000, 0, 3000, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      add_vec(1, 1000, 1000, (k <= 8) ? 125 * k : 1000, (k <= 8) ? 3000 - 250 * k : 1000,
              (k >= 9) ? 2 : 1, (k == 9) ? 1 : 0, 0, (k >= 9) ? 20 : 0, 0);
    for (int j = 1; j <= 11; j++)
      add_vec(1, 2000, 0, (j <= 8) ? 1000 + 125 * j : 2000, (j <= 8) ? 1000 - 125 * j : 0,
              (j >= 10) ? 3 : 2, 0, (j == 10) ? 1 : 0, 20, (j >= 10) ? 13 : 0);
    add_vec(0, 2000, 0, 2000, 0, 0, 0, 0, 20, 13);
    add_vec(0, 2000, 0, 2000, 0, 0, 0, 0, 20, 13);

    do_reset();
    #1;
    check("reset avg_current", avg_current, 0);
    check("reset avg_voltage", avg_voltage, 0);
    check("reset gap_state", gap_state, 0);
    check("reset discharge_start", discharge_start, 0);
    check("reset discharge_end", discharge_end, 0);
    check("reset delay_cycles", delay_cycles, 0);
    check("reset discharge_cycles", discharge_cycles, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].pulse, vecs[i].cur, vecs[i].volt);
      step();
      check($sformatf("vec%0d avg_current", i), avg_current, vecs[i].e_ai);
      check($sformatf("vec%0d avg_voltage", i), avg_voltage, vecs[i].e_av);
      check($sformatf("vec%0d gap_state", i), gap_state, vecs[i].e_state);
      check($sformatf("vec%0d discharge_start", i), discharge_start, vecs[i].e_start);
      check($sformatf("vec%0d discharge_end", i), discharge_end, vecs[i].e_end);
      check($sformatf("vec%0d delay_cycles", i), delay_cycles, vecs[i].e_delay);
      check($sformatf("vec%0d discharge_cycles", i), discharge_cycles, vecs[i].e_dcyc);
    end

    // pulse_on drops while discharging: end pulse and length latch.
    do_reset();
    drive(1, 1000, 1000);
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("drop k%0d gap_state", k), gap_state, (k >= 8) ? 2 : 1);
      check($sformatf("drop k%0d discharge_start", k), discharge_start, (k == 8) ? 1 : 0);
    end
    check("drop delay_cycles", delay_cycles, 7);
    drive(0, 1000, 1000);
    step();
    check("drop exit gap_state", gap_state, 0);
    check("drop exit discharge_end", discharge_end, 1);
    check("drop exit discharge_cycles", discharge_cycles, 6);
    step();
    check("drop after discharge_end", discharge_end, 0);
    check("drop after gap_state", gap_state, 0);

    // pulse_on drops on the very edge the discharge debounce completes.
    do_reset();
    drive(1, 1000, 1000);
    repeat (7) step();
    check("race pre gap_state", gap_state, 1);
    drive(0, 1000, 1000);
    step();
    check("race gap_state", gap_state, 0);
    check("race discharge_start", discharge_start, 0);
    check("race delay_cycles", delay_cycles, 0);
    step();
    check("race after discharge_start", discharge_start, 0);

    // Asynchronous reset in the middle of a discharge.
    do_reset();
    drive(1, 1000, 1000);
    repeat (10) step();
    check("arst pre gap_state", gap_state, 2);
    check("arst pre delay_cycles", delay_cycles, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst gap_state", gap_state, 0);
    check("arst avg_voltage", avg_voltage, 0);
    check("arst delay_cycles", delay_cycles, 0);
    check("arst discharge_end", discharge_end, 0);
    step();
    check("arst held discharge_end", discharge_end, 0);
    check("arst held discharge_cycles", discharge_cycles, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Glitch: condition true 3 cycles, false 1 (voltage spike), true 4.
    do_reset();
    drive(1, 0, 1000);
    repeat (10) step();
    check("glitch settle gap_state", gap_state, 1);
    check("glitch settle avg_voltage", avg_voltage, 1000);
    starts = 0;
    for (int j = 1; j <= 14; j++) begin
      drive(1, 1000, (j == 7) ? 9000 : (j == 8) ? -7000 : 1000);
      step();
      if (discharge_start) starts++;
      check($sformatf("glitch j%0d gap_state", j), gap_state, (j >= 12) ? 2 : 1);
      if (j == 7) check("glitch spike avg_voltage", avg_voltage, 2000);
    end
    check("glitch start count", starts, 1);

    // Negative samples and rounding toward -inf.
    do_reset();
    drive(0, 5, -3);
    step();
    check("round avg_voltage", avg_voltage, -1);
    check("round avg_current", avg_current, 0);
    check("round gap_state", gap_state, 0);
    drive(1, -4000, -4000);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("neg k%0d gap_state", k), gap_state, 1);
      if (k == 1) begin
        check("neg first avg_voltage", avg_voltage, -501);
        check("neg first avg_current", avg_current, -500);
      end
    end
    check("neg avg_voltage", avg_voltage, -4000);
    check("neg avg_current", avg_current, -4000);
    check("neg delay_cycles", delay_cycles, 0);

    // Ignition delay saturation.
    do_reset();
    drive(1, 0, 3000);
    repeat (66000) step();
    check("sat open gap_state", gap_state, 1);
    check("sat open delay_cycles", delay_cycles, 0);
    drive(1, 1000, 1000);
    repeat (9) step();
    check("sat gap_state", gap_state, 2);
    check("sat discharge_start", discharge_start, 1);
    check("sat delay_cycles", delay_cycles, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
